param_uni_shift: RTL and testbench

PARAM_UNI_SHIFT -- requirements
Module: param_uni_shift

---
 rtl/param_uni_shift.sv | 123 ++++++++++++
 tb/tb_param_uni_shift.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_uni_shift.sv
// Parameterised universal shift register with single-step and counted multi-step operation.
// A small IDLE/RUN/DONE controller repeats a latched operation for a programmable number of edges.
module param_uni_shift #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] in,
  input  logic             serial_in_right,
  input  logic             serial_in_left,
  input  logic [2:0]       select,
  input  logic             en,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] out,
  output logic             serial_out_right,
  output logic             serial_out_left,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROTR = 3'b100,
    OP_ROTL = 3'b101,
    OP_ASR  = 3'b110,
    OP_RSVD = 3'b111
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             busy_q, done_q;

  // One shift-register step; serial inputs and parallel data are whatever is live this edge.
  function automatic logic [WIDTH-1:0] apply_op(
    input op_t              op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] d,
    input logic             sir,
    input logic             sil
  );
    logic [WIDTH-1:0] r;
    r = cur;
    case (op)
      OP_SHR:  r = {sir, cur[WIDTH-1:1]};
      OP_SHL:  r = {cur[WIDTH-2:0], sil};
      OP_LOAD: r = d;
      OP_ROTR: r = {cur[0], cur[WIDTH-1:1]};
      OP_ROTL: r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ASR:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: r = cur;
    endcase
    return r;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case can infer a latch.
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_t'(select);
          rem_d   = count;
          state_d = (count == '0) ? DONE : RUN;
        end else if (en) begin
          out_d = apply_op(op_t'(select), out_q, in, serial_in_right, serial_in_left);
        end
      end
      RUN: begin
        out_d = apply_op(op_q, out_q, in, serial_in_right, serial_in_left);
        rem_d = rem_q - CW'(1);
        if (rem_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD;
      rem_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign out              = out_q;
  assign serial_out_right = out_q[0];
  assign serial_out_left  = out_q[WIDTH-1];
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_param_uni_shift.sv
// Directed self-checking bench for param_uni_shift at WIDTH=8.
// Inputs change 1 ns after each rising edge; outputs are checked there as well.
module tb_param_uni_shift;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH) + 1;

  logic             clk;
  logic             clear;
  logic [WIDTH-1:0] in;
  logic             serial_in_right;
  logic             serial_in_left;
  logic [2:0]       select;
  logic             en;
  logic             start;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] out;
  logic             serial_out_right;
  logic             serial_out_left;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  param_uni_shift #(.WIDTH(WIDTH)) dut (
    .clk              (clk),
    .clear            (clear),
    .in               (in),
    .serial_in_right  (serial_in_right),
    .serial_in_left   (serial_in_left),
    .select           (select),
    .en               (en),
    .start            (start),
    .count            (count),
    .out              (out),
    .serial_out_right (serial_out_right),
    .serial_out_left  (serial_out_left),
    .busy             (busy),
    .done             (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear = 1'b0; en = 1'b0; start = 1'b0; select = 3'b000; count = '0;
    in = '0; serial_in_right = 1'b0; serial_in_left = 1'b0;
    #2 clear = 1'b1;

    // Load something nonzero, then reset asynchronously with random inputs.
    en = 1'b1; select = 3'b011; in = 8'hFF;
    step();
    check("pre_reset_load", out, 8'hFF);
    en = 1'(($urandom) & 1); start = 1'(($urandom) & 1); select = 3'($urandom);
    in = 8'($urandom); count = CW'($urandom);
    serial_in_right = 1'(($urandom) & 1); serial_in_left = 1'(($urandom) & 1);
    clear = 1'b0;
    #1;
    check("reset_out_async", out, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    step();
    check("reset_held_out", out, 8'h00);
    en = 1'b0; start = 1'b0; count = '0;
    clear = 1'b1;

    // Single steps.
    en = 1'b1; select = 3'b011; in = 8'hA5;
    step();
    check("step_load", out, 8'hA5);
    check("step_load_busy", busy, 1'b0);
    select = 3'b001; serial_in_right = 1'b1;
    step();
    check("step_shr", out, 8'hD2);
    check("step_shr_sor", serial_out_right, 1'b0);
    check("step_shr_sol", serial_out_left, 1'b1);
    select = 3'b010; serial_in_left = 1'b1;
    step();
    check("step_shl", out, 8'hA5);
    select = 3'b000;
    step();
    check("step_hold", out, 8'hA5);
    en = 1'b0;

    // Rotate right x3; select/count changes during the run are ignored.
    start = 1'b1; select = 3'b100; count = CW'(3);
    step();
    check("rotr_start_busy", busy, 1'b1);
    check("rotr_start_out", out, 8'hA5);
    start = 1'b0; select = 3'b111; count = CW'(9);
    step();
    check("rotr_e1_out", out, 8'hD2);
    check("rotr_e1_busy", busy, 1'b1);
    step();
    check("rotr_e2_out", out, 8'h69);
    check("rotr_e2_busy", busy, 1'b1);
    step();
    check("rotr_e3_out", out, 8'hB4);
    check("rotr_e3_done", done, 1'b1);
    check("rotr_e3_busy", busy, 1'b0);
    step();
    check("rotr_idle_done", done, 1'b0);
    check("rotr_idle_busy", busy, 1'b0);

    // Rotate left x8 returns to the start value.
    start = 1'b1; select = 3'b101; count = CW'(8);
    step();
    start = 1'b0;
    check("rotl8_start_busy", busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      if (i < 7) check("rotl8_busy", busy, 1'b1);
      else begin
        check("rotl8_done", done, 1'b1);
        check("rotl8_out", out, 8'hB4);
      end
    end
    step();
    check("rotl8_idle_done", done, 1'b0);

    // Arithmetic shift right x4 with start pulsed mid-run.
    en = 1'b1; select = 3'b011; in = 8'h96;
    step();
    en = 1'b0;
    start = 1'b1; select = 3'b110; count = CW'(4);
    step();
    check("asr_start_busy", busy, 1'b1);
    start = 1'b0; select = 3'b000; count = '0;
    step();
    check("asr_e1_out", out, 8'hCB);
    start = 1'b1;
    step();
    check("asr_e2_out", out, 8'hE5);
    start = 1'b0;
    step();
    check("asr_e3_busy", busy, 1'b1);
    step();
    check("asr_e4_out", out, 8'hF9);
    check("asr_e4_done", done, 1'b1);
    step();
    check("asr_after_done", done, 1'b0);
    check("asr_after_busy", busy, 1'b0);
    check("asr_after_out", out, 8'hF9);

    // Zero count goes straight to DONE; en is ignored in DONE.
    start = 1'b1; select = 3'b001; count = '0;
    step();
    check("zero_busy", busy, 1'b0);
    check("zero_done", done, 1'b1);
    check("zero_out", out, 8'hF9);
    start = 1'b0; en = 1'b1; select = 3'b011; in = 8'h00;
    step();
    en = 1'b0;
    check("zero_after_done", done, 1'b0);
    check("done_ignores_en", out, 8'hF9);

    // Reserved hold code still runs its count.
    start = 1'b1; select = 3'b111; count = CW'(2);
    step();
    start = 1'b0;
    step();
    check("hold_run_busy", busy, 1'b1);
    step();
    check("hold_run_done", done, 1'b1);
    check("hold_run_out", out, 8'hF9);
    step();

    // Shift left x10 with serial_in_left=1 saturates to all ones.
    start = 1'b1; select = 3'b010; count = CW'(10); serial_in_left = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i < 9) check("shl10_busy", busy, 1'b1);
      else begin
        check("shl10_done", done, 1'b1);
        check("shl10_out", out, 8'hFF);
      end
    end
    step();

    // Serial input sampled live during a run.
    start = 1'b1; select = 3'b001; count = CW'(2); serial_in_right = 1'b1;
    step();
    start = 1'b0; serial_in_right = 1'b0;
    step();
    check("live_e1_out", out, 8'h7F);
    serial_in_right = 1'b1;
    step();
    check("live_e2_out", out, 8'hBF);
    check("live_e2_done", done, 1'b1);
    step();

    // Abort a count=5 run during its second cycle.
    en = 1'b1; select = 3'b011; in = 8'hA5;
    step();
    en = 1'b0;
    start = 1'b1; select = 3'b100; count = CW'(5);
    step();
    start = 1'b0;
    step();
    check("abort_pre_out", out, 8'hD2);
    clear = 1'b0;
    #1;
    check("abort_out", out, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    step();
    check("abort_held_done", done, 1'b0);
    clear = 1'b1;
    step();
    check("post_abort_done", done, 1'b0);
    check("post_abort_busy", busy, 1'b0);
    en = 1'b1; select = 3'b011; in = 8'h3C;
    step();
    en = 1'b0;
    check("post_abort_load", out, 8'h3C);
    start = 1'b1; select = 3'b101; count = CW'(2);
    step();
    start = 1'b0;
    step();
    check("post_abort_e1", out, 8'h78);
    step();
    check("post_abort_out", out, 8'hF0);
    check("post_abort_run_done", done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
